hcode_job_sched: RTL and testbench

- Job sequencer that shares the single 32-bit ap_fifo host stream pair between N_IP HLS accelerator cores.
- Each host job starts with a header word. The header selects a core, the number of words to feed it, and the number of words to collect from it.
- The block passes payload through combinationally to the selected core, returns that core's results to the host, and closes each job with a status trailer word.
- It sits between the Xillybus interface FIFOs and the ip_loopback-style cores, all on ip_clk.

---
 rtl/hcode_sched_pkg.sv | 44 ++++
 rtl/hcode_job_sched_if.sv | 35 +++
 rtl/hcode_sched_mux.sv | 55 +++++
 rtl/hcode_job_sched.sv | 220 ++++++++++++++++++++++
 tb/tb_hcode_job_sched.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hcode_sched_pkg.sv
// Shared definitions for the host job sequencer.
// Holds the FSM state type, trailer status codes, header/trailer field
// positions, the length counter width and the trailer packing helper.
package hcode_sched_pkg;

  localparam int unsigned LEN_W  = 14;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StFeed,
    StCollect,
    StDrain,
    StTrail
  } state_e;

  localparam logic [7:0] ST_OK       = 8'd0;
  localparam logic [7:0] ST_BAD_DEST = 8'd1;
  localparam logic [7:0] ST_TIMEOUT  = 8'd2;

  // Header: {dest, in_len, out_len}
  localparam int unsigned HDR_DEST_MSB    = 31;
  localparam int unsigned HDR_DEST_LSB    = 28;
  localparam int unsigned HDR_IN_LEN_MSB  = 27;
  localparam int unsigned HDR_IN_LEN_LSB  = 14;
  localparam int unsigned HDR_OUT_LEN_MSB = 13;
  localparam int unsigned HDR_OUT_LEN_LSB = 0;

  // Trailer: {4'h0, dest, status, words_returned}
  localparam int unsigned TRL_DEST_MSB   = 27;
  localparam int unsigned TRL_DEST_LSB   = 24;
  localparam int unsigned TRL_STATUS_MSB = 23;
  localparam int unsigned TRL_STATUS_LSB = 16;
  localparam int unsigned TRL_COUNT_MSB  = 15;
  localparam int unsigned TRL_COUNT_LSB  = 0;

  function automatic logic [DATA_W-1:0] make_trailer(input logic [3:0]       dest,
                                                     input logic [7:0]       status,
                                                     input logic [LEN_W-1:0] count);
    // words_returned is 16 bits wide; the 14-bit count is zero-extended
    return {4'h0, dest, status, 2'b00, count};
  endfunction

endpackage

// File: rtl/hcode_job_sched_if.sv
// Host FIFO pair plus core-bank ap_fifo signals of the job sequencer.
//   Host side : in_dout/in_empty_n/in_read (input FIFO, show-ahead),
//               out_din/out_write/out_full_n (output FIFO).
//   Core side : ip_in_dout broadcast data, per-core ip_in_empty_n/ip_in_read,
//               per-core ip_out_din (32 bits per core)/ip_out_write/ip_out_full_n.
// Modports: slave = the sequencer, master = the surrounding FIFOs and cores.
interface hcode_job_sched_if #(
  parameter int unsigned N_IP = 2
) ();

  logic [31:0]        in_dout;
  logic               in_empty_n;
  logic               in_read;
  logic [31:0]        out_din;
  logic               out_write;
  logic               out_full_n;

  logic [31:0]        ip_in_dout;
  logic [N_IP-1:0]    ip_in_empty_n;
  logic [N_IP-1:0]    ip_in_read;
  logic [N_IP*32-1:0] ip_out_din;
  logic [N_IP-1:0]    ip_out_write;
  logic [N_IP-1:0]    ip_out_full_n;

  modport slave (
    input  in_dout, in_empty_n, out_full_n, ip_in_read, ip_out_din, ip_out_write,
    output in_read, out_din, out_write, ip_in_dout, ip_in_empty_n, ip_out_full_n
  );

  modport master (
    output in_dout, in_empty_n, out_full_n, ip_in_read, ip_out_din, ip_out_write,
    input  in_read, out_din, out_write, ip_in_dout, ip_in_empty_n, ip_out_full_n
  );

endinterface

// File: rtl/hcode_sched_mux.sv
// Core-bank steering for the job sequencer, purely combinational.
//   i_sel           : selected core index (may exceed N_IP-1; then nothing matches)
//   i_in_avail      : input-available flag to route to the selected core
//   i_out_space     : output-space flag to route to the selected core
//   i_ip_in_read    : per-core input pops
//   i_ip_out_din    : per-core result data, 32 bits per core
//   i_ip_out_write  : per-core result pushes
//   o_ip_in_empty_n : per-core input flags (only the selected core may see 1)
//   o_ip_out_full_n : per-core output flags (only the selected core may see 1)
//   o_sel_read      : pop request of the selected core
//   o_sel_write     : push request of the selected core
//   o_sel_din       : result data of the selected core
module hcode_sched_mux #(
  parameter int unsigned N_IP = 2
) (
  input  logic [3:0]         i_sel,
  input  logic               i_in_avail,
  input  logic               i_out_space,
  input  logic [N_IP-1:0]    i_ip_in_read,
  input  logic [N_IP*32-1:0] i_ip_out_din,
  input  logic [N_IP-1:0]    i_ip_out_write,
  output logic [N_IP-1:0]    o_ip_in_empty_n,
  output logic [N_IP-1:0]    o_ip_out_full_n,
  output logic               o_sel_read,
  output logic               o_sel_write,
  output logic [31:0]        o_sel_din
);

  // Selection and demux are kept in separate processes so the flag inputs
  // (which the top derives from o_sel_read/o_sel_write) form no comb loop.
  always_comb begin
    o_sel_read  = 1'b0;
    o_sel_write = 1'b0;
    o_sel_din   = '0;
    for (int k = 0; k < int'(N_IP); k++) begin
      if (i_sel == 4'(k)) begin
        o_sel_read  = i_ip_in_read[k];
        o_sel_write = i_ip_out_write[k];
        o_sel_din   = i_ip_out_din[32*k +: 32];
      end
    end
  end

  always_comb begin
    o_ip_in_empty_n = '0;
    o_ip_out_full_n = '0;
    for (int k = 0; k < int'(N_IP); k++) begin
      if (i_sel == 4'(k)) begin
        o_ip_in_empty_n[k] = i_in_avail;
        o_ip_out_full_n[k] = i_out_space;
      end
    end
  end

endmodule

// File: rtl/hcode_job_sched.sv
// Job sequencer sharing one 32-bit host stream pair between N_IP cores.
// Each job: header {dest, in_len, out_len}, in_len payload words passed
// through to core dest, out_len result words returned, then a trailer
// {4'h0, dest, status, words_returned}.
//   ap_clk, ap_rst_n : clock, asynchronous active-low reset
//   bus              : host FIFO pair and core-bank signals (slave side)
//   busy             : a job is in progress
//   job_count        : jobs completed (counted at trailer write), wraps
module hcode_job_sched
  import hcode_sched_pkg::*;
#(
  parameter int unsigned N_IP    = 2,
  parameter int unsigned TIMEOUT = 1048576
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  hcode_job_sched_if.slave bus,
  output logic             busy,
  output logic [15:0]      job_count
);

  localparam bit          TimeoutEn = (TIMEOUT != 0);
  localparam int unsigned StallW    = TimeoutEn ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [StallW-1:0] StallLast = StallW'(TIMEOUT - 1);

  state_e             r_state, w_state_d;
  logic [3:0]         r_dest;
  logic [LEN_W-1:0]   r_in_len, r_out_len, r_in_cnt, r_out_cnt;
  logic [StallW-1:0]  r_stall;
  logic [7:0]         r_status, w_status_d;
  logic [15:0]        r_job_count;

  logic [3:0]         w_hdr_dest;
  logic [LEN_W-1:0]   w_hdr_in_len, w_hdr_out_len;
  logic               w_hdr_pop, w_pop, w_push, w_stall, w_stall_hit;
  logic               w_in_avail, w_out_space;
  logic               w_in_done, w_out_done, w_in_last, w_out_last;
  logic               w_sel_read, w_sel_write;
  logic [31:0]        w_sel_din;
  logic               w_in_read, w_out_write;
  logic [31:0]        w_out_din;

  assign w_hdr_dest    = bus.in_dout[HDR_DEST_MSB:HDR_DEST_LSB];
  assign w_hdr_in_len  = bus.in_dout[HDR_IN_LEN_MSB:HDR_IN_LEN_LSB];
  assign w_hdr_out_len = bus.in_dout[HDR_OUT_LEN_MSB:HDR_OUT_LEN_LSB];

  assign w_in_done  = (r_in_cnt == r_in_len);
  assign w_out_done = (r_out_cnt == r_out_len);
  assign w_in_last  = ((r_in_cnt + LEN_W'(1)) == r_in_len);
  assign w_out_last = ((r_out_cnt + LEN_W'(1)) == r_out_len);

  assign w_stall_hit = TimeoutEn && w_stall && (r_stall == StallLast);

  hcode_sched_mux #(
    .N_IP (N_IP)
  ) u_mux (
    .i_sel           (r_dest),
    .i_in_avail      (w_in_avail),
    .i_out_space     (w_out_space),
    .i_ip_in_read    (bus.ip_in_read),
    .i_ip_out_din    (bus.ip_out_din),
    .i_ip_out_write  (bus.ip_out_write),
    .o_ip_in_empty_n (bus.ip_in_empty_n),
    .o_ip_out_full_n (bus.ip_out_full_n),
    .o_sel_read      (w_sel_read),
    .o_sel_write     (w_sel_write),
    .o_sel_din       (w_sel_din)
  );

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d  = r_state;
    w_status_d = r_status;
    unique case (r_state)
      StIdle: begin
        if (w_hdr_pop) begin
          if (32'(w_hdr_dest) >= N_IP) begin
            w_state_d  = StDrain;
            w_status_d = ST_BAD_DEST;
          end else begin
            w_state_d  = (w_hdr_in_len == '0) ? StCollect : StFeed;
            w_status_d = ST_OK;
          end
        end
      end
      StFeed: begin
        if (w_pop && w_in_last) begin
          w_state_d = (r_out_len == '0) ? StTrail : StCollect;
        end else if (w_stall_hit) begin
          w_state_d  = StDrain;
          w_status_d = ST_TIMEOUT;
        end
      end
      StCollect: begin
        if (w_out_done || (w_push && w_out_last)) begin
          w_state_d = StTrail;
        end else if (w_stall_hit) begin
          w_state_d  = StTrail;
          w_status_d = ST_TIMEOUT;
        end
      end
      StDrain: begin
        if (w_in_done || (w_pop && w_in_last)) begin
          w_state_d = StTrail;
        end
      end
      StTrail: begin
        if (bus.out_full_n) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Output and handshake logic
  always_comb begin
    w_hdr_pop   = 1'b0;
    w_pop       = 1'b0;
    w_push      = 1'b0;
    w_stall     = 1'b0;
    w_in_avail  = 1'b0;
    w_out_space = 1'b0;
    w_in_read   = 1'b0;
    w_out_write = 1'b0;
    w_out_din   = '0;
    unique case (r_state)
      StIdle: begin
        // Reset gating keeps in_read low while ap_rst_n is asserted
        w_in_read = ap_rst_n & bus.in_empty_n;
        w_hdr_pop = w_in_read;
      end
      StFeed: begin
        w_in_avail = bus.in_empty_n;
        w_pop      = w_sel_read & bus.in_empty_n;
        w_in_read  = w_pop;
        w_stall    = bus.in_empty_n & ~w_sel_read;
      end
      StCollect: begin
        w_out_din = w_sel_din;
        // out_len == 0 reaches here with nothing to collect
        if (!w_out_done) begin
          w_out_space = bus.out_full_n;
          w_push      = w_sel_write & bus.out_full_n;
          w_out_write = w_push;
          w_stall     = bus.out_full_n & ~w_sel_write;
        end
      end
      StDrain: begin
        if (!w_in_done) begin
          w_in_read = bus.in_empty_n;
          w_pop     = w_in_read;
        end
      end
      StTrail: begin
        w_out_din   = make_trailer(r_dest, r_status, r_out_cnt);
        w_out_write = bus.out_full_n;
      end
      default: ;
    endcase
  end

  // Job datapath: header fields, word counters, watchdog, job counter
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_dest      <= '0;
      r_in_len    <= '0;
      r_out_len   <= '0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_stall     <= '0;
      r_status    <= ST_OK;
      r_job_count <= '0;
    end else begin
      r_status <= w_status_d;
      if (w_hdr_pop) begin
        r_dest    <= w_hdr_dest;
        r_in_len  <= w_hdr_in_len;
        r_out_len <= w_hdr_out_len;
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_pop) begin
          r_in_cnt <= r_in_cnt + LEN_W'(1);
        end
        if (w_push) begin
          r_out_cnt <= r_out_cnt + LEN_W'(1);
        end
      end
      // Only core-attributable stalls count; any transfer or state change clears
      if (!w_stall || (w_state_d != r_state)) begin
        r_stall <= '0;
      end else begin
        r_stall <= r_stall + StallW'(1);
      end
      if ((r_state == StTrail) && bus.out_full_n) begin
        r_job_count <= r_job_count + 16'd1;
      end
    end
  end

  assign bus.in_read   = w_in_read;
  assign bus.out_write = w_out_write;
  assign bus.out_din   = w_out_din;
  // Broadcast data follows the host head word; forced to 0 while in reset
  assign bus.ip_in_dout = ap_rst_n ? bus.in_dout : 32'h0;

  assign busy      = (r_state != StIdle);
  assign job_count = r_job_count;

endmodule

// File: tb/tb_hcode_job_sched.sv
module tb_hcode_job_sched;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        busy;
  logic [15:0] job_count;

  hcode_job_sched_if #(.N_IP(2)) bus ();

  hcode_job_sched #(
    .N_IP    (2),
    .TIMEOUT (16)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .bus       (bus),
    .busy      (busy),
    .job_count (job_count)
  );

  always #5 ap_clk = ~ap_clk;

  logic [31:0] host_q[$], out_q[$], rx0_q[$], rx1_q[$], tx0_q[$], tx1_q[$];
  logic        out_en;
  logic [1:0]  rd_en, wr_en;
  int n_cmp, n_mis;
  int mon_e0, mon_eany, mon_fany, mon_busy, mon_lowsync, mon_viol;

  task automatic drive();
    bus.in_empty_n   = (host_q.size() > 0);
    bus.in_dout      = (host_q.size() > 0) ? host_q[0] : 32'h0;
    bus.out_full_n   = out_en;
    bus.ip_in_read   = rd_en;
    bus.ip_out_write = {wr_en[1] && (tx1_q.size() > 0), wr_en[0] && (tx0_q.size() > 0)};
    bus.ip_out_din   = {(tx1_q.size() > 0) ? tx1_q[0] : 32'h0,
                        (tx0_q.size() > 0) ? tx0_q[0] : 32'h0};
  endtask

  // Environment: host FIFOs and two cores. Handshakes are sampled on the
  // falling edge and committed just after the following rising edge.
  initial begin : env
    logic p_in, p_out, p_rx0, p_rx1, p_tx0, p_tx1;
    logic [31:0] d_out, d_ip;
    forever begin
      @(negedge ap_clk);
      p_in  = bus.in_read;
      p_out = bus.out_write;
      d_out = bus.out_din;
      d_ip  = bus.ip_in_dout;
      p_rx0 = bus.ip_in_empty_n[0] & bus.ip_in_read[0];
      p_rx1 = bus.ip_in_empty_n[1] & bus.ip_in_read[1];
      p_tx0 = bus.ip_out_full_n[0] & bus.ip_out_write[0];
      p_tx1 = bus.ip_out_full_n[1] & bus.ip_out_write[1];
      if (bus.ip_in_empty_n[0]) mon_e0++;
      if (|bus.ip_in_empty_n) mon_eany++;
      if (|bus.ip_out_full_n) mon_fany++;
      if (busy) mon_busy++;
      if (!bus.out_full_n && busy && (bus.ip_out_full_n == 2'b00)) mon_lowsync++;
      if (!bus.out_full_n && ((bus.ip_out_full_n != 2'b00) || bus.out_write)) mon_viol++;
      @(posedge ap_clk);
      #1;
      if (p_in && (host_q.size() > 0)) void'(host_q.pop_front());
      if (p_out) out_q.push_back(d_out);
      if (p_rx0) rx0_q.push_back(d_ip);
      if (p_rx1) rx1_q.push_back(d_ip);
      if (p_tx0 && (tx0_q.size() > 0)) void'(tx0_q.pop_front());
      if (p_tx1 && (tx1_q.size() > 0)) void'(tx1_q.pop_front());
      drive();
    end
  end

  task automatic flush();
    host_q.delete(); out_q.delete(); rx0_q.delete(); rx1_q.delete();
    tx0_q.delete(); tx1_q.delete();
  endtask

  task automatic wait_out(input int n, input int budget, input string name);
    int cyc = 0;
    while ((out_q.size() < n) && (cyc < budget)) begin
      @(posedge ap_clk); #2;
      cyc++;
    end
    n_cmp++;
    if (out_q.size() < n) begin
      n_mis++;
      $display("FAIL %s: host words got %0d required %0d (cycle budget expired)",
               name, out_q.size(), n);
    end
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    flush();
    host_q.push_back(32'hDEADBEEF);
    tx0_q.push_back(32'h55);
    rd_en = 2'b11; wr_en = 2'b11; out_en = 1'b1;
    drive();
    repeat (3) @(negedge ap_clk);
    n_cmp++; if (bus.in_read !== 1'b0) begin n_mis++; $display("FAIL rst_in_read: got %b required 0", bus.in_read); end
    n_cmp++; if (bus.out_write !== 1'b0) begin n_mis++; $display("FAIL rst_out_write: got %b required 0", bus.out_write); end
    n_cmp++; if (bus.out_din !== 32'h0) begin n_mis++; $display("FAIL rst_out_din: got %h required 0", bus.out_din); end
    n_cmp++; if (bus.ip_in_empty_n !== 2'b00) begin n_mis++; $display("FAIL rst_ip_in_empty_n: got %b required 00", bus.ip_in_empty_n); end
    n_cmp++; if (bus.ip_out_full_n !== 2'b00) begin n_mis++; $display("FAIL rst_ip_out_full_n: got %b required 00", bus.ip_out_full_n); end
    n_cmp++; if (bus.ip_in_dout !== 32'h0) begin n_mis++; $display("FAIL rst_ip_in_dout: got %h required 0", bus.ip_in_dout); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL rst_busy: got %b required 0", busy); end
    n_cmp++; if (job_count !== 16'h0) begin n_mis++; $display("FAIL rst_job_count: got %h required 0", job_count); end
    flush();
    rd_en = 2'b00; wr_en = 2'b00;
    drive();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (2) @(negedge ap_clk);
  endtask

  // Core 1 job: 3 words in, 2 words echoed back
  task automatic test_job_core1(input logic [15:0] exp_jobs);
    logic [31:0] exp_rx[3];
    logic [31:0] exp_out[3];
    exp_rx  = '{32'hA, 32'hB, 32'hC};
    exp_out = '{32'hA, 32'hB, 32'h01000002};
    flush();
    tx1_q.push_back(32'hA); tx1_q.push_back(32'hB);
    rd_en = 2'b11; wr_en = 2'b11; out_en = 1'b1;
    mon_e0 = 0;
    host_q.push_back(32'h1000C002);
    host_q.push_back(32'hA); host_q.push_back(32'hB); host_q.push_back(32'hC);
    wait_out(3, 100, "job1_out");
    repeat (2) @(negedge ap_clk);
    n_cmp++; if (rx1_q.size() !== 3) begin n_mis++; $display("FAIL job1_rx1_count: got %0d required 3", rx1_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (rx1_q[i] !== exp_rx[i]) begin n_mis++; $display("FAIL job1_rx1[%0d]: got %h required %h", i, rx1_q[i], exp_rx[i]); end
      n_cmp++; if (out_q[i] !== exp_out[i]) begin n_mis++; $display("FAIL job1_out[%0d]: got %h required %h", i, out_q[i], exp_out[i]); end
    end
    n_cmp++; if (rx0_q.size() !== 0) begin n_mis++; $display("FAIL job1_rx0_count: got %0d required 0", rx0_q.size()); end
    n_cmp++; if (mon_e0 !== 0) begin n_mis++; $display("FAIL job1_core0_empty_n: got %0d cycles required 0", mon_e0); end
    n_cmp++; if (job_count !== exp_jobs) begin n_mis++; $display("FAIL job1_job_count: got %0d required %0d", job_count, exp_jobs); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL job1_busy_after: got %b required 0", busy); end
    n_cmp++; if (host_q.size() !== 0) begin n_mis++; $display("FAIL job1_host_left: got %0d required 0", host_q.size()); end
  endtask

  task automatic test_bad_dest();
    flush();
    rd_en = 2'b11; wr_en = 2'b00; out_en = 1'b1;
    mon_eany = 0;
    host_q.push_back(32'h50008000); host_q.push_back(32'h1); host_q.push_back(32'h2);
    wait_out(1, 100, "bad_out");
    repeat (2) @(negedge ap_clk);
    n_cmp++; if (out_q[0] !== 32'h05010000) begin n_mis++; $display("FAIL bad_trailer: got %h required 05010000", out_q[0]); end
    n_cmp++; if (host_q.size() !== 0) begin n_mis++; $display("FAIL bad_drained: got %0d left required 0", host_q.size()); end
    n_cmp++; if (mon_eany !== 0) begin n_mis++; $display("FAIL bad_empty_n: got %0d cycles required 0", mon_eany); end
    n_cmp++; if ((rx0_q.size() + rx1_q.size()) !== 0) begin n_mis++; $display("FAIL bad_core_rx: got %0d required 0", rx0_q.size() + rx1_q.size()); end
    n_cmp++; if (job_count !== 16'd2) begin n_mis++; $display("FAIL bad_job_count: got %0d required 2", job_count); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_out[5];
    int cyc;
    exp_out = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h01000004};
    flush();
    tx1_q.push_back(32'h11); tx1_q.push_back(32'h22);
    tx1_q.push_back(32'h33); tx1_q.push_back(32'h44);
    rd_en = 2'b00; wr_en = 2'b11; out_en = 1'b1;
    mon_lowsync = 0; mon_viol = 0;
    host_q.push_back(32'h10000004);
    cyc = 0;
    while ((out_q.size() < 2) && (cyc < 100)) begin
      @(posedge ap_clk); #2;
      cyc++;
    end
    out_en = 1'b0;
    drive();
    repeat (10) @(posedge ap_clk);
    #2;
    out_en = 1'b1;
    drive();
    wait_out(5, 100, "bp_out");
    repeat (2) @(negedge ap_clk);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_q[i] !== exp_out[i]) begin n_mis++; $display("FAIL bp_out[%0d]: got %h required %h", i, out_q[i], exp_out[i]); end
    end
    n_cmp++; if (out_q.size() !== 5) begin n_mis++; $display("FAIL bp_out_count: got %0d required 5", out_q.size()); end
    n_cmp++; if (mon_lowsync !== 10) begin n_mis++; $display("FAIL bp_full_n_low_cycles: got %0d required 10", mon_lowsync); end
    n_cmp++; if (mon_viol !== 0) begin n_mis++; $display("FAIL bp_leak: got %0d cycles required 0", mon_viol); end
    n_cmp++; if (job_count !== 16'd3) begin n_mis++; $display("FAIL bp_job_count: got %0d required 3", job_count); end
  endtask

  task automatic test_timeout();
    flush();
    rd_en = 2'b10; wr_en = 2'b00; out_en = 1'b1;
    mon_e0 = 0;
    host_q.push_back(32'h00008001); host_q.push_back(32'h7); host_q.push_back(32'h8);
    wait_out(1, 200, "to_out");
    repeat (2) @(negedge ap_clk);
    n_cmp++; if (out_q[0] !== 32'h00020000) begin n_mis++; $display("FAIL to_trailer: got %h required 00020000", out_q[0]); end
    n_cmp++; if (mon_e0 !== 16) begin n_mis++; $display("FAIL to_stall_cycles: got %0d required 16", mon_e0); end
    n_cmp++; if (host_q.size() !== 0) begin n_mis++; $display("FAIL to_drained: got %0d left required 0", host_q.size()); end
    n_cmp++; if ((rx0_q.size() + rx1_q.size()) !== 0) begin n_mis++; $display("FAIL to_core_rx: got %0d required 0", rx0_q.size() + rx1_q.size()); end
    n_cmp++; if (job_count !== 16'd4) begin n_mis++; $display("FAIL to_job_count: got %0d required 4", job_count); end
  endtask

  task automatic test_zero_len();
    flush();
    rd_en = 2'b11; wr_en = 2'b00; out_en = 1'b1;
    mon_busy = 0; mon_eany = 0; mon_fany = 0;
    host_q.push_back(32'h00000000);
    wait_out(1, 50, "zero_out");
    repeat (2) @(negedge ap_clk);
    n_cmp++; if (out_q[0] !== 32'h00000000) begin n_mis++; $display("FAIL zero_trailer: got %h required 00000000", out_q[0]); end
    n_cmp++; if (out_q.size() !== 1) begin n_mis++; $display("FAIL zero_out_count: got %0d required 1", out_q.size()); end
    n_cmp++; if (mon_busy !== 2) begin n_mis++; $display("FAIL zero_busy_cycles: got %0d required 2", mon_busy); end
    n_cmp++; if ((mon_eany + mon_fany) !== 0) begin n_mis++; $display("FAIL zero_core_flags: got %0d cycles required 0", mon_eany + mon_fany); end
    n_cmp++; if (job_count !== 16'd5) begin n_mis++; $display("FAIL zero_job_count: got %0d required 5", job_count); end
  endtask

  task automatic test_reset_mid();
    flush();
    rd_en = 2'b00; wr_en = 2'b00; out_en = 1'b1;
    host_q.push_back(32'h1000C002);
    host_q.push_back(32'hA); host_q.push_back(32'hB); host_q.push_back(32'hC);
    repeat (5) @(posedge ap_clk);
    #2;
    n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL mid_busy_before: got %b required 1", busy); end
    n_cmp++; if (bus.ip_in_empty_n !== 2'b10) begin n_mis++; $display("FAIL mid_feed_flags: got %b required 10", bus.ip_in_empty_n); end
    ap_rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL mid_busy: got %b required 0", busy); end
    n_cmp++; if (bus.in_read !== 1'b0) begin n_mis++; $display("FAIL mid_in_read: got %b required 0", bus.in_read); end
    n_cmp++; if (bus.ip_in_empty_n !== 2'b00) begin n_mis++; $display("FAIL mid_ip_in_empty_n: got %b required 00", bus.ip_in_empty_n); end
    n_cmp++; if (bus.out_write !== 1'b0) begin n_mis++; $display("FAIL mid_out_write: got %b required 0", bus.out_write); end
    n_cmp++; if (job_count !== 16'd0) begin n_mis++; $display("FAIL mid_job_count: got %0d required 0", job_count); end
    repeat (2) @(negedge ap_clk);
    flush();
    drive();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (2) @(negedge ap_clk);
    test_job_core1(16'd1);
  endtask

  initial begin
    n_cmp = 0; n_mis = 0;
    mon_e0 = 0; mon_eany = 0; mon_fany = 0; mon_busy = 0; mon_lowsync = 0; mon_viol = 0;
    out_en = 1'b1; rd_en = 2'b00; wr_en = 2'b00;
    ap_rst_n = 1'b0;
    drive();
    test_reset();
    test_job_core1(16'd1);
    test_bad_dest();
    test_backpressure();
    test_timeout();
    test_zero_len();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation still running at %0t, required finished", $time);
    $fatal(1);
  end

endmodule
